timer_bcd_n: RTL and testbench

Parametrised successor of the 60 s stopwatch/countdown timer. It is an N-digit BCD up/down timer with a configurable tick rate, pause/resume, preset load, lap capture and a sticky done flag. It sits between the debounced key front-end and the display driver. All key inputs arrive as single-cycle pulses, already debounced and synchronised upstream.

---
 rtl/timer_bcd_n_if.sv | 40 ++++
 rtl/timer_bcd_n.sv | 191 +++++++++++++++++++
 tb/tb_timer_bcd_n.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/timer_bcd_n_if.sv
// Command/status bundle between the key front-end, the timer and the display driver.
// With SEG_DECODE_EN defined the bundle also carries the registered 7-segment patterns.
interface timer_bcd_n_if #(
  parameter int DIGITS = 4
);
  logic                  start_up;
  logic                  start_down;
  logic                  pause_tgl;
  logic                  clear;
  logic                  lap;
  logic [4*DIGITS-1:0]   preset;
  logic [4*DIGITS-1:0]   count_bcd;
  logic [4*DIGITS-1:0]   lap_bcd;
  logic                  running;
  logic                  paused;
  logic                  done;
  logic                  wrap;
  logic                  tick;
`ifdef SEG_DECODE_EN
  logic [7*DIGITS-1:0]   seg;
`endif

  // key front-end / display side
  modport master (
`ifdef SEG_DECODE_EN
    input  seg,
`endif
    output start_up, start_down, pause_tgl, clear, lap, preset,
    input  count_bcd, lap_bcd, running, paused, done, wrap, tick
  );

  // timer side
  modport slave (
`ifdef SEG_DECODE_EN
    output seg,
`endif
    input  start_up, start_down, pause_tgl, clear, lap, preset,
    output count_bcd, lap_bcd, running, paused, done, wrap, tick
  );
endinterface

// File: rtl/timer_bcd_n.sv
// N-digit BCD up/down timer: prescaled tick, pause/resume, preset load, lap
// capture, sticky done. Optional SEG_DECODE_EN adds registered active-low
// abcdefg patterns per digit.

// One BCD digit: increment with carry and decrement with borrow.
module timer_bcd_digit (
  input  logic [3:0] d,
  input  logic       ci,
  input  logic       bi,
  output logic [3:0] inc,
  output logic       co,
  output logic [3:0] dec,
  output logic       bo
);
  // carry/borrow ripple for a single decade
  always_comb begin
    inc = d;
    co  = 1'b0;
    dec = d;
    bo  = 1'b0;
    if (ci) begin
      if (d >= 4'd9) begin inc = 4'd0; co = 1'b1; end
      else           inc = d + 4'd1;
    end
    if (bi) begin
      if (d == 4'd0) begin dec = 4'd9; bo = 1'b1; end
      else           dec = d - 4'd1;
    end
  end
endmodule

module timer_bcd_n #(
  parameter int DIGITS  = 4,
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 10
) (
  input  logic         clk_50M,
  input  logic         rst_n,
  timer_bcd_n_if.slave bus
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW  = 4 * DIGITS;

  typedef enum logic [2:0] {IDLE, RUN_UP, RUN_DOWN, PAUSED, DONE} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   lap_q, lap_d;
  logic            dir_dn_q, dir_dn_d;   // direction to resume after PAUSED
  logic            wrap_q, wrap_d;

  logic            run, tick, pause_ok;
  logic [CW-1:0]   inc_val, dec_val, pre_clamp;
  logic [DIGITS:0] cy, bw;

  assign cy[0] = 1'b1;
  assign bw[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    timer_bcd_digit u_dig (
      .d   (cnt_q[4*g +: 4]),
      .ci  (cy[g]),
      .bi  (bw[g]),
      .inc (inc_val[4*g +: 4]),
      .co  (cy[g+1]),
      .dec (dec_val[4*g +: 4]),
      .bo  (bw[g+1])
    );
    assign pre_clamp[4*g +: 4] = (bus.preset[4*g +: 4] > 4'd9) ? 4'd9 : bus.preset[4*g +: 4];
  end

  assign run      = (state_q == RUN_UP) || (state_q == RUN_DOWN);
  assign tick     = run && (presc_q == PW'(DIV - 1));
  assign pause_ok = bus.pause_tgl && (run || state_q == PAUSED);

  // state, count, prescaler and lap registers
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      presc_q  <= '0;
      cnt_q    <= '0;
      lap_q    <= '0;
      dir_dn_q <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      cnt_q    <= cnt_d;
      lap_q    <= lap_d;
      dir_dn_q <= dir_dn_d;
      wrap_q   <= wrap_d;
    end
  end

  // next state: counting first, then the single highest-priority command overrides
  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    cnt_d    = cnt_q;
    lap_d    = lap_q;
    dir_dn_d = dir_dn_q;
    wrap_d   = 1'b0;

    if (run) presc_d = tick ? '0 : presc_q + PW'(1);

    if (tick) begin
      if (state_q == RUN_UP) begin
        cnt_d  = inc_val;
        wrap_d = cy[DIGITS];
      end else if ((dec_val == '0) || bw[DIGITS]) begin
        // final step lands on zero; an underflow can only mean a corrupt count
        cnt_d   = '0;
        state_d = DONE;
      end else begin
        cnt_d = dec_val;
      end
    end

    if (bus.clear) begin
      state_d = IDLE;
      cnt_d   = '0;
      presc_d = '0;
      wrap_d  = 1'b0;
    end else if (bus.start_down) begin
      presc_d = '0;
      wrap_d  = 1'b0;
      if (pre_clamp == '0) begin
        state_d = DONE;
        cnt_d   = '0;
      end else begin
        state_d = RUN_DOWN;
        cnt_d   = pre_clamp;
      end
    end else if (bus.start_up) begin
      state_d = RUN_UP;
      cnt_d   = '0;
      presc_d = '0;
      wrap_d  = 1'b0;
    end else if (pause_ok) begin
      if (run) begin
        dir_dn_d = (state_q == RUN_DOWN);
        // the pause cycle does not consume a prescaler count unless it is the tick itself
        if (!tick) presc_d = presc_q;
        if (state_d != DONE) state_d = PAUSED;
      end else begin
        state_d = dir_dn_q ? RUN_DOWN : RUN_UP;
      end
    end else if (bus.lap) begin
      lap_d = cnt_q;
    end
  end

  assign bus.count_bcd = cnt_q;
  assign bus.lap_bcd   = lap_q;
  assign bus.running   = run;
  assign bus.paused    = (state_q == PAUSED);
  assign bus.done      = (state_q == DONE);
  assign bus.wrap      = wrap_q;
  assign bus.tick      = tick;

`ifdef SEG_DECODE_EN
  logic [7*DIGITS-1:0] seg_q;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b0000001;
      4'd1:    seg7 = 7'b1001111;
      4'd2:    seg7 = 7'b0010010;
      4'd3:    seg7 = 7'b0000110;
      4'd4:    seg7 = 7'b1001100;
      4'd5:    seg7 = 7'b0100100;
      4'd6:    seg7 = 7'b0100000;
      4'd7:    seg7 = 7'b0001111;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0000100;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // registered per-digit decode, one cycle behind count_bcd
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) seg_q <= {DIGITS{7'b0000001}};
    else
      for (int i = 0; i < DIGITS; i++) seg_q[7*i +: 7] <= seg7(cnt_q[4*i +: 4]);
  end

  assign bus.seg = seg_q;
`endif
endmodule

// File: tb/tb_timer_bcd_n.sv
// Scoreboard bench for timer_bcd_n (DIGITS=2, DIV=10): stimulus pushes
// cycle-stamped expectations, a negedge monitor pops and compares them.
module tb_timer_bcd_n;
  typedef struct {
    int         cyc;
    logic [7:0] cnt;
    logic [7:0] lp;
    logic [4:0] fl;    // {running, paused, done, wrap, tick}
    string      nm;
  } exp_t;

  localparam logic [4:0] SU = 5'b10000, SD = 5'b01000, PT = 5'b00100,
                         CL = 5'b00010, LP = 5'b00001;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t q[$];

  timer_bcd_n_if #(.DIGITS(2)) bus ();

  timer_bcd_n #(.DIGITS(2), .CLK_HZ(100), .TICK_HZ(10)) dut (
    .clk_50M (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // keep the queue ordered by cycle
  task automatic push(input int c, input logic [7:0] cnt, input logic [7:0] lp,
                      input logic [4:0] fl, input string nm);
    exp_t e;
    int   k;
    e.cyc = c; e.cnt = cnt; e.lp = lp; e.fl = fl; e.nm = nm;
    k = 0;
    while (k < q.size() && q[k].cyc <= c) k++;
    q.insert(k, e);
  endtask

  task automatic pulse_at(input int at, input logic [4:0] c);
    while (cyc < at) begin @(posedge clk); #1; end
    {bus.start_up, bus.start_down, bus.pause_tgl, bus.clear, bus.lap} = c;
    @(posedge clk); #1;
    {bus.start_up, bus.start_down, bus.pause_tgl, bus.clear, bus.lap} = '0;
  endtask

  task automatic wait_cyc(input int at);
    while (cyc < at) begin @(posedge clk); #1; end
  endtask

  // monitor: compare every expectation due this cycle
  always @(negedge clk) begin
    logic [4:0] fl;
    exp_t e;
    fl = {bus.running, bus.paused, bus.done, bus.wrap, bus.tick};
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      tests++;
      if (e.cyc < cyc) begin
        fails++;
        $display("FAIL %s: check for cycle %0d skipped (now %0d)", e.nm, e.cyc, cyc);
      end else if (bus.count_bcd !== e.cnt || bus.lap_bcd !== e.lp || fl !== e.fl) begin
        fails++;
        $display("FAIL %s @%0d: got cnt=%h lap=%h fl=%b, want cnt=%h lap=%h fl=%b",
                 e.nm, cyc, bus.count_bcd, bus.lap_bcd, fl, e.cnt, e.lp, e.fl);
      end
    end
  end

  initial begin
    int n, m, d, p, r, z, a;
    {bus.start_up, bus.start_down, bus.pause_tgl, bus.clear, bus.lap} = '0;
    bus.preset = 8'h00;
    #2 rst_n = 1'b0;
    push(2, 8'h00, 8'h00, 5'b00000, "reset_state");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    push(cyc + 1, 8'h00, 8'h00, 5'b00000, "idle_after_reset");

    // up count, lap at 37, wrap 99 -> 00
    n = cyc + 3;
    push(n + 1,    8'h00, 8'h00, 5'b10000, "up_start");
    push(n + 10,   8'h00, 8'h00, 5'b10001, "up_first_tick");
    push(n + 11,   8'h01, 8'h00, 5'b10000, "up_cnt_01");
    push(n + 21,   8'h02, 8'h00, 5'b10000, "up_cnt_02");
    push(n + 376,  8'h37, 8'h37, 5'b10000, "lap_37");
    push(n + 991,  8'h99, 8'h37, 5'b10000, "up_cnt_99");
    push(n + 1000, 8'h99, 8'h37, 5'b10001, "up_tick_100");
    push(n + 1001, 8'h00, 8'h37, 5'b10010, "up_wrap");
    push(n + 1002, 8'h00, 8'h37, 5'b10000, "up_after_wrap");
    pulse_at(n, SU);
    pulse_at(n + 375, LP);

    // clear beats start_up
    m = n + 1010;
    push(m + 1,  8'h00, 8'h37, 5'b00000, "clear_over_start");
    push(m + 15, 8'h00, 8'h37, 5'b00000, "idle_no_tick");
    pulse_at(m, CL | SU);

    // countdown from 15 to done
    d = m + 20;
    bus.preset = 8'h15;
    push(d + 1,   8'h15, 8'h37, 5'b10000, "dn_load");
    push(d + 51,  8'h10, 8'h37, 5'b10000, "dn_cnt_10");
    push(d + 61,  8'h09, 8'h37, 5'b10000, "dn_borrow_09");
    push(d + 150, 8'h01, 8'h37, 5'b10001, "dn_last_tick");
    push(d + 151, 8'h00, 8'h37, 5'b00100, "dn_done");
    push(d + 210, 8'h00, 8'h37, 5'b00100, "dn_done_hold");
    pulse_at(d, SD);

    // pause at prescaler 4, resume 200 cycles later
    p = d + 220;
    r = p + 206;
    push(p + 5,   8'h00, 8'h37, 5'b10000, "pre_pause");
    push(p + 6,   8'h00, 8'h37, 5'b01000, "paused");
    push(p + 106, 8'h00, 8'h37, 5'b01000, "paused_frozen");
    push(r,       8'h00, 8'h37, 5'b01000, "still_paused");
    push(r + 5,   8'h00, 8'h37, 5'b10000, "resume_no_tick_yet");
    push(r + 6,   8'h00, 8'h37, 5'b10001, "resume_tick");
    push(r + 7,   8'h01, 8'h37, 5'b10000, "resume_cnt_01");
    push(r + 9,   8'h15, 8'h37, 5'b10000, "lap_ignored_with_sd");
    pulse_at(p, SU);
    pulse_at(p + 5, PT);
    pulse_at(r, PT);
    pulse_at(r + 8, SD | LP);

    // digit clamp
    bus.preset = 8'hA3;
    push(r + 13, 8'h93, 8'h37, 5'b10000, "preset_clamp_93");
    pulse_at(r + 12, SD);

    // zero preset goes straight to done
    z = r + 32;
    wait_cyc(r + 14);
    bus.preset = 8'h00;
    push(z + 1,  8'h00, 8'h37, 5'b00100, "zero_preset_done");
    push(z + 10, 8'h00, 8'h37, 5'b00100, "zero_preset_no_tick");
    pulse_at(z, SD);

    // async reset mid countdown
    a = z + 20;
    bus.preset = 8'h15;
    push(a + 1,  8'h15, 8'h37, 5'b10000, "rst_pre_run");
    push(a + 21, 8'h13, 8'h37, 5'b10000, "rst_pre_cnt_13");
    push(a + 25, 8'h00, 8'h00, 5'b00000, "rst_async_immediate");
    push(a + 27, 8'h00, 8'h00, 5'b00000, "rst_held");
    push(a + 30, 8'h00, 8'h00, 5'b00000, "rst_release_idle");
    push(a + 45, 8'h00, 8'h00, 5'b00000, "rst_no_tick");
    pulse_at(a, SD);
    wait_cyc(a + 25);
    #1 rst_n = 1'b0;
    wait_cyc(a + 28);
    rst_n = 1'b1;

    wait_cyc(a + 47);
    @(posedge clk); #1;
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d checks never reached, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
